serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 83 ++++++++
 tb/tb_serial_add_sub.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one full-adder slice per clock, LSB first.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, co_q, ov_q;
  logic             s_d, c_d, last_d;
  logic [WIDTH-1:0] sum_d;
  always_comb begin
    s_d    = a_q[0] ^ b_q[0] ^ c_q;
    c_d    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    sum_d  = {s_d, sum_q[WIDTH-1:1]};
    last_d = cnt_q == CW'(WIDTH - 1);
  end
  // subtraction is a + ~b + 1: b is inverted on capture and the carry seeded with m
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          sum_q <= sum_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= sum_d;
            co_q     <= c_d;
            ov_q     <= c_q ^ c_d;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b ^ {WIDTH{m}};
            c_q     <= m;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed vector table plus hand-written multi-cycle sequences.
module tb_serial_add_sub;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       m = 1'b0;
  logic       busy, done, carry_out, overflow;
  logic [7:0] result;
  int         ncmp = 0, nerr = 0;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .m(m),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       m;
    logic [7:0] r;
    logic       co, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                    output int lat, output int nbusy);
    @(negedge clk);
    a = ia; b = ib; m = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
  endtask

  initial begin
    vec_t       tbl[8];
    int         lat, nb;
    logic [7:0] prev;
    logic       seen;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op(tbl[i].a, tbl[i].b, tbl[i].m, lat, nb);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_busy_cycles", i), nb, 8);
      chk($sformatf("v%0d_result", i), result, tbl[i].r);
      chk($sformatf("v%0d_carry", i), carry_out, tbl[i].co);
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // start during RUN must be ignored; outputs hold the previous result until done
    prev = result;
    @(negedge clk);
    a = 8'h05; b = 8'h03; m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin start = 1'b1; a = 8'hAA; m = 1'b1; end
      else start = 1'b0;
      if (lat == 7) chk("ign_hold_result", result, prev);
    end
    chk("ign_latency", lat, 8);
    chk("ign_result", result, 8'h08);
    chk("ign_carry", carry_out, 0);
    @(negedge clk);
    chk("ign_no_second_op", busy, 0);

    // reset mid-RUN aborts, and reset beats start on the same edge
    @(negedge clk);
    a = 8'h7F; b = 8'h01; m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_ovf", overflow, 0);
    start = 1'b0; rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    op(8'hFF, 8'h01, 1'b0, lat, nb);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_result", result, 8'h00);
    chk("post_rst_carry", carry_out, 1);

    // start held through DONE: back-to-back with no IDLE cycle
    @(negedge clk);
    a = 8'h05; b = 8'h03; m = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_first_latency", lat, 8);
    chk("b2b_first_result", result, 8'h08);
    a = 8'h7F; b = 8'h01;
    @(negedge clk);
    lat++;
    start = 1'b0;
    chk("b2b_no_idle_busy", busy, 1);
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    chk("b2b_second_latency", lat, 17);
    chk("b2b_second_result", result, 8'h80);
    chk("b2b_second_ovf", overflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
